// File: rtl/ina226_target_model_if.sv
// Host-side register load and transaction report bus of the INA226 target model.
interface ina226_target_model_if;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic [7:0]  rd_addr;
    logic        busy;

    modport master (
        output ld_en, ld_addr, ld_data,
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, busy
    );

    modport slave (
        input  ld_en, ld_addr, ld_data,
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, busy
    );
endinterface

// File: rtl/ina226_target_model.sv
// I2C target emulating the INA226 16-bit register map; SCL/SDA are oversampled on sys_clk.
module ina226_target_model #(
    parameter int unsigned NUM_REGS = 8,
    parameter logic [15:0] REG0_RST = 16'h4127,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned SDA_HOLD = 8
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       SCL,
    inout  wire                        SDA,
    input  logic [6:0]                 dev_addr,
    ina226_target_model_if.slave       host
);

    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned FCNT_W = $clog2(FILT_LEN + 1);
    localparam int unsigned HOLD_W = $clog2(SDA_HOLD + 1);
    localparam logic [7:0]  NREGS8 = 8'(NUM_REGS);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WR_MSB, ST_WR_MSB_ACK, ST_WR_LSB, ST_WR_LSB_ACK,
        ST_TX_MSB, ST_TX_MSB_MACK, ST_TX_LSB, ST_TX_LSB_MACK, ST_WAIT_STOP
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_scl_sync, r_sda_sync;
    logic                r_scl_f, r_sda_f, r_scl_d, r_sda_d;
    logic [FCNT_W-1:0]   r_scl_cnt, r_sda_cnt;
    logic [3:0]          r_bit;
    logic [7:0]          r_sr, r_ptr, r_wr_msb, r_tx, r_tx_lsb;
    logic [15:0]         r_regs [NUM_REGS];
    logic                r_sda_low, r_sda_pend;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_wr_valid, r_rd_valid, r_busy;
    logic [7:0]          r_wr_addr, r_rd_addr;
    logic [15:0]         r_wr_data;

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_last;
    logic w_bit_step, w_rx_shift, w_ptr_ld, w_msb_ld, w_commit;
    logic w_rd_latch, w_tx_shift, w_tx_lsb_ld, w_drv_low;
    logic [7:0]  w_rx_byte;
    logic [15:0] w_rd_word;

    assign SDA = r_sda_low ? 1'b0 : 1'bz;

    // Synchronizer plus glitch filter: a level change must persist FILT_LEN samples.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_scl_cnt  <= '0;
            r_sda_cnt  <= '0;
        end else begin
            r_scl_sync <= {r_scl_sync[0], SCL};
            r_sda_sync <= {r_sda_sync[0], SDA};
            r_scl_d    <= r_scl_f;
            r_sda_d    <= r_sda_f;
            if (r_scl_sync[1] == r_scl_f) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == FCNT_W'(FILT_LEN - 1)) begin
                r_scl_f   <= r_scl_sync[1];
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + FCNT_W'(1);
            end
            if (r_sda_sync[1] == r_sda_f) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == FCNT_W'(FILT_LEN - 1)) begin
                r_sda_f   <= r_sda_sync[1];
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + FCNT_W'(1);
            end
        end
    end

    assign w_scl_rise = r_scl_f & ~r_scl_d;
    assign w_scl_fall = ~r_scl_f & r_scl_d;
    assign w_start    = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
    assign w_stop     = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;
    assign w_last     = (r_bit == 4'd7);
    assign w_rx_byte  = {r_sr[6:0], r_sda_f};
    assign w_rd_word  = (r_ptr < NREGS8) ? r_regs[r_ptr[IDX_W-1:0]] : 16'h0000;

    always_ff @(posedge sys_clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Protocol sequencing: all bit-level progress happens on filtered SCL rising edges.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_step  = 1'b0;
        w_rx_shift  = 1'b0;
        w_ptr_ld    = 1'b0;
        w_msb_ld    = 1'b0;
        w_commit    = 1'b0;
        w_rd_latch  = 1'b0;
        w_tx_shift  = 1'b0;
        w_tx_lsb_ld = 1'b0;
        if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
        end else if (w_scl_rise) begin
            case (r_state)
                ST_ADDR: begin
                    w_rx_shift = 1'b1;
                    w_bit_step = 1'b1;
                    if (w_last)
                        w_state_nxt = (w_rx_byte[7:1] == dev_addr) ? ST_ADDR_ACK : ST_WAIT_STOP;
                end
                ST_ADDR_ACK: begin
                    if (r_sr[0]) begin
                        w_state_nxt = ST_TX_MSB;
                        w_rd_latch  = 1'b1;
                    end else begin
                        w_state_nxt = ST_PTR;
                    end
                end
                ST_PTR: begin
                    w_rx_shift = 1'b1;
                    w_bit_step = 1'b1;
                    if (w_last) begin
                        w_ptr_ld    = 1'b1;
                        w_state_nxt = ST_PTR_ACK;
                    end
                end
                ST_PTR_ACK: w_state_nxt = ST_WR_MSB;
                ST_WR_MSB: begin
                    w_rx_shift = 1'b1;
                    w_bit_step = 1'b1;
                    if (w_last) begin
                        w_msb_ld    = 1'b1;
                        w_state_nxt = ST_WR_MSB_ACK;
                    end
                end
                ST_WR_MSB_ACK: w_state_nxt = ST_WR_LSB;
                ST_WR_LSB: begin
                    w_rx_shift = 1'b1;
                    w_bit_step = 1'b1;
                    if (w_last) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_WR_LSB_ACK;
                    end
                end
                ST_WR_LSB_ACK: w_state_nxt = ST_WAIT_STOP;
                ST_TX_MSB: begin
                    w_tx_shift = 1'b1;
                    w_bit_step = 1'b1;
                    if (w_last) w_state_nxt = ST_TX_MSB_MACK;
                end
                ST_TX_MSB_MACK: begin
                    w_tx_lsb_ld = 1'b1;
                    w_state_nxt = ST_TX_LSB;
                end
                ST_TX_LSB: begin
                    w_tx_shift = 1'b1;
                    w_bit_step = 1'b1;
                    if (w_last) w_state_nxt = ST_TX_LSB_MACK;
                end
                ST_TX_LSB_MACK: w_state_nxt = ST_WAIT_STOP;
                default: ;
            endcase
        end
    end

    // Level to present on SDA during the SCL low phase that follows the current state.
    always_comb begin
        w_drv_low = 1'b0;
        case (r_state)
            ST_ADDR_ACK, ST_PTR_ACK, ST_WR_MSB_ACK, ST_WR_LSB_ACK: w_drv_low = 1'b1;
            ST_TX_MSB, ST_TX_LSB:                                  w_drv_low = ~r_tx[7];
            default:                                               w_drv_low = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_bit      <= '0;
            r_sr       <= '0;
            r_ptr      <= '0;
            r_wr_msb   <= '0;
            r_tx       <= '0;
            r_tx_lsb   <= '0;
            r_sda_low  <= 1'b0;
            r_sda_pend <= 1'b0;
            r_hold_cnt <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_addr  <= '0;
            r_busy     <= 1'b0;
        end else begin
            if (w_start || w_stop)  r_bit <= '0;
            else if (w_bit_step)    r_bit <= w_last ? 4'd0 : r_bit + 4'd1;
            if (w_rx_shift) r_sr     <= w_rx_byte;
            if (w_ptr_ld)   r_ptr    <= w_rx_byte;
            if (w_msb_ld)   r_wr_msb <= w_rx_byte;
            if (w_rd_latch) begin
                r_tx     <= w_rd_word[15:8];
                r_tx_lsb <= w_rd_word[7:0];
            end else if (w_tx_lsb_ld) begin
                r_tx <= r_tx_lsb;
            end else if (w_tx_shift) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end
            r_wr_valid <= w_commit;
            if (w_commit) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= {r_wr_msb, w_rx_byte};
            end
            r_rd_valid <= w_rd_latch;
            if (w_rd_latch) r_rd_addr <= r_ptr;
            if (w_start)     r_busy <= 1'b1;
            else if (w_stop) r_busy <= 1'b0;
            // SDA only moves SDA_HOLD cycles into an SCL low phase, never while SCL is high.
            if (w_start || w_stop) begin
                r_sda_low  <= 1'b0;
                r_hold_cnt <= '0;
            end else if (w_scl_fall) begin
                r_sda_pend <= w_drv_low;
                r_hold_cnt <= HOLD_W'(SDA_HOLD);
            end else if (r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                if (r_hold_cnt == HOLD_W'(1) && !r_scl_f) r_sda_low <= r_sda_pend;
            end
        end
    end

    // Host load first so an I2C commit to the same register in the same cycle wins.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                r_regs[IDX_W'(i)] <= (i == 0) ? REG0_RST : 16'h0000;
        end else begin
            if (host.ld_en && (host.ld_addr < NREGS8))
                r_regs[host.ld_addr[IDX_W-1:0]] <= host.ld_data;
            if (w_commit && (r_ptr < NREGS8))
                r_regs[r_ptr[IDX_W-1:0]] <= {r_wr_msb, w_rx_byte};
        end
    end

    assign host.wr_valid = r_wr_valid;
    assign host.wr_addr  = r_wr_addr;
    assign host.wr_data  = r_wr_data;
    assign host.rd_valid = r_rd_valid;
    assign host.rd_addr  = r_rd_addr;
    assign host.busy     = r_busy;

endmodule
